// File: rtl/refill_line_writer_if.sv
// Refill writer bundle: request, read-burst beats, RAM write port,
// critical-word forward and completion status.
interface refill_line_writer_if #(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 2
);
  localparam int W  = NUM_COL * COL_WIDTH;
  localparam int AW = INDEX_WIDTH + OFFSET_WIDTH;

  logic                    req_valid;
  logic                    req_ready;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;

  logic                    beat_valid;
  logic                    beat_ready;
  logic [W-1:0]            beat_data;
  logic                    beat_last;

  logic [NUM_COL-1:0]      ram_wen;
  logic [AW-1:0]           ram_addr;
  logic [W-1:0]            ram_din;

  logic                    crit_valid;
  logic [W-1:0]            crit_data;
  logic                    done;
  logic                    err;

  modport master (
    output req_valid,
    output req_index,
    output req_offset,
    output beat_valid,
    output beat_data,
    output beat_last,
    input  req_ready,
    input  beat_ready,
    input  ram_wen,
    input  ram_addr,
    input  ram_din,
    input  crit_valid,
    input  crit_data,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_index,
    input  req_offset,
    input  beat_valid,
    input  beat_data,
    input  beat_last,
    output req_ready,
    output beat_ready,
    output ram_wen,
    output ram_addr,
    output ram_din,
    output crit_valid,
    output crit_data,
    output done,
    output err
  );
endinterface

// File: rtl/refill_line_writer.sv
// Cache line refill writer: critical-word-first burst into the data RAM,
// with critical word forward, done pulse and sticky burst-length error.
module refill_line_writer #(
  parameter int NUM_COL      = 4,
  parameter int COL_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  refill_line_writer_if.slave  bus
);
  localparam int W  = NUM_COL * COL_WIDTH;
  localparam int AW = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int N  = 2 ** OFFSET_WIDTH;
  localparam int CW = OFFSET_WIDTH + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic [OFFSET_WIDTH-1:0] wptr_q, wptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_COL-1:0]      wen_q, wen_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [W-1:0]            din_q, din_d;
  logic                    critv_q, critv_d;
  logic [W-1:0]            crit_q, crit_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic is_idle;
  logic is_fill;
  logic is_drain;
  logic is_done;

  assign is_idle  = (state_q == S_IDLE);
  assign is_fill  = (state_q == S_FILL);
  assign is_drain = (state_q == S_DRAIN);
  assign is_done  = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    wen_d   = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    critv_d = 1'b0;
    crit_d  = crit_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (1'b1)
      is_idle: begin
        if (bus.req_valid) begin
          idx_d   = bus.req_index;
          wptr_d  = bus.req_offset;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      is_fill: begin
        if (bus.beat_valid) begin
          wen_d  = '1;
          addr_d = {idx_q, wptr_q};
          din_d  = bus.beat_data;
          wptr_d = wptr_q + OFFSET_WIDTH'(1);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == '0) begin
            critv_d = 1'b1;
            crit_d  = bus.beat_data;
          end
          if (cnt_q == CNT_LAST) begin
            // Overlong burst: keep the full line, swallow the excess
            if (bus.beat_last) begin
              state_d = S_DONE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (bus.beat_last) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      is_drain: begin
        if (bus.beat_valid && bus.beat_last) begin
          state_d = S_DONE;
        end
      end
      is_done: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      critv_q <= 1'b0;
      crit_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      critv_q <= critv_d;
      crit_q  <= crit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = is_idle;
  assign bus.beat_ready = is_fill | is_drain;
  assign bus.ram_wen    = wen_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.crit_valid = critv_q;
  assign bus.crit_data  = crit_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_refill_line_writer.sv
// Bench for refill_line_writer: directed bursts plus random bursts,
// checked against a line-level model of expected RAM writes.
module tb_refill_line_writer;
  localparam int NC = 4;
  localparam int CB = 8;
  localparam int IW = 8;
  localparam int OW = 2;
  localparam int N  = 4;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] din;
    logic [3:0]  wen;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  refill_line_writer_if #(
    .NUM_COL(NC), .COL_WIDTH(CB),
    .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)
  ) bus ();

  refill_line_writer #(
    .NUM_COL(NC), .COL_WIDTH(CB),
    .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  wr_t wq[$];
  int cyc = 0;
  int crit_n = 0;
  int crit_cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  logic [31:0] crit_seen = '0;
  logic [31:0] beats[$];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.ram_wen != 0)
          wq.push_back('{addr: bus.ram_addr, din: bus.ram_din,
                         wen: bus.ram_wen, cyc: cyc});
        if (bus.crit_valid) begin
          crit_n++;
          crit_cyc = cyc;
          crit_seen = bus.crit_data;
        end
        if (bus.done) begin
          done_n++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_obs();
    wq.delete();
    crit_n = 0;
    done_n = 0;
  endtask

  task automatic do_req(input int idx, input int off);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_wait", t < 50, 1);
    bus.req_valid  = 1'b1;
    bus.req_index  = 8'(idx);
    bus.req_offset = 2'(off);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("req_ready_busy", bus.req_ready, 0);
    check("beat_ready_fill", bus.beat_ready, 1);
    check("err_cleared", bus.err, 0);
  endtask

  task automatic send_beats(input int len, input int mode);
    int t;
    bit gap;
    for (int i = 0; i < len; i++) begin
      gap = (mode == 1 && i > 0) ||
            (mode == 2 && $urandom_range(0, 1) == 1);
      if (gap) begin
        bus.beat_valid = 1'b0;
        @(negedge clk);
      end
      bus.beat_valid = 1'b1;
      bus.beat_data  = beats[i];
      bus.beat_last  = (i == len - 1);
      t = 0;
      while (!bus.beat_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("beat_wait", t < 50, 1);
      @(negedge clk);
    end
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    check("done_not_early", done_n, 0);
  endtask

  task automatic run(input int idx, input int off,
                     input int len, input int mode);
    int n;
    logic [9:0] ea;
    clear_obs();
    beats.delete();
    for (int i = 0; i < len; i++) beats.push_back($urandom);
    do_req(idx, off);
    send_beats(len, mode);
    repeat (4) @(negedge clk);
    n = (len < N) ? len : N;
    check("n_writes", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      ea = 10'(idx * N + (off + i) % N);
      check("wr_addr", wq[i].addr, ea);
      check("wr_data", wq[i].din, beats[i]);
      check("wr_wen", wq[i].wen, 4'hF);
    end
    check("crit_count", crit_n, 1);
    check("crit_word", crit_seen, beats[0]);
    check("crit_held", bus.crit_data, beats[0]);
    if (wq.size() > 0) begin
      check("crit_with_1st_wr", crit_cyc, wq[0].cyc);
      if (len <= N && done_n == 1)
        check("done_after_last_wr", done_cyc, wq[wq.size()-1].cyc + 1);
    end
    check("done_count", done_n, 1);
    check("err", bus.err, len != N);
    check("idle_ready", bus.req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_index  = '0;
    bus.req_offset = '0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    bus.beat_last  = 1'b0;
    #12;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_beat_ready", bus.beat_ready, 0);
    check("rst_wen", bus.ram_wen, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_din", bus.ram_din, 0);
    check("rst_crit_valid", bus.crit_valid, 0);
    check("rst_crit_data", bus.crit_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;

    run(8'h12, 0, 4, 0);
    run($urandom_range(0, 255), 2, 4, 0);
    run($urandom_range(0, 255), $urandom_range(0, 3), 4, 1);
    run($urandom_range(0, 255), 1, 2, 0);
    run($urandom_range(0, 255), 3, 6, 0);

    clear_obs();
    do_req(8'h5A, 1);
    for (int i = 0; i < 2; i++) begin
      bus.beat_valid = 1'b1;
      bus.beat_data  = $urandom;
      bus.beat_last  = 1'b0;
      @(negedge clk);
    end
    bus.beat_valid = 1'b0;
    check("wen_before_rst", bus.ram_wen, 4'hF);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wen", bus.ram_wen, 0);
    check("mid_rst_req_ready", bus.req_ready, 1);
    check("mid_rst_beat_ready", bus.beat_ready, 0);
    check("mid_rst_crit_valid", bus.crit_valid, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h5A, 1, 4, 0);

    for (int k = 0; k < 20; k++)
      run($urandom_range(0, 255), $urandom_range(0, 3),
          $urandom_range(1, 6), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
